// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a TXDATA/STATUS register pair.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (tx low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx high), then next byte or IDLE
module uart_tx_periph #(
    parameter logic [9:0] BASE_ADDR    = 10'h3F0,
    parameter int         CLKS_PER_BIT = 104,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  width,
    input  logic        write,
    output logic [31:0] data_out,
    output logic        tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2) begin : g_param_check
        $error("uart_tx_periph: CLKS_PER_BIT and FIFO_DEPTH must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              overflow;

    logic        hit;
    logic        push_req;
    logic        clr_ovf;
    logic        bit_done;
    logic        pop;
    logic        push;
    logic        busy;
    logic        q_empty;
    logic        q_full;
    logic [7:0]  q_head;
    logic [2:0]  q_count;
    logic [31:0] status;
    logic        unused;

    assign unused   = ^{data_in[31:8], width[3:1], address[1:0]};
    assign hit      = address[9:3] == BASE_ADDR[9:3];
    assign push_req = write && width[0] && hit && !address[2];
    assign clr_ovf  = write && width[0] && hit && address[2] && data_in[3];
    assign bit_done = baud_cnt == '0;

    // The head leaves the queue when a frame starts, either from IDLE or straight out of STOP.
    assign pop  = !q_empty && (state == IDLE || (state == STOP && bit_done));
    assign push = push_req && (!q_full || pop);
    assign busy = (state != IDLE) || !q_empty;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign q_empty = count == '0;
    assign q_full  = count == CNT_W'(FIFO_DEPTH);
    assign q_head  = mem[rd_ptr];
    assign q_count = 3'(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // When full, a push lands on the slot being popped this same edge.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in[7:0];
    end
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign q_empty = !hold_valid;
    assign q_full  = hold_valid;
    assign q_head  = hold_data;
    assign q_count = {2'b00, hold_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_data  <= data_in[7:0];
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        baud_cnt <= BAUD_LAST;
                        shift    <= q_head;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_LAST;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        shift    <= {1'b0, shift[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            state    <= START;
                            baud_cnt <= BAUD_LAST;
                            shift    <= q_head;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (push_req && q_full && !pop)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    assign status = {25'd0, q_count, overflow, q_empty, q_full, busy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_out <= '0;
        else
            data_out <= (hit && address[2]) ? status : 32'd0;
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: a serial-line monitor decodes frames and checks them
// against a queue of expected bytes filled by the stimulus process.
module tb_uart_tx_periph;

    localparam int CPB = 4;
    localparam logic [9:0] BASE = 10'h3F0;
    localparam logic [9:0] STAT = 10'h3F4;

`ifdef UART_TX_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    // Hand-computed STATUS values / counts for each queue configuration
    localparam logic [31:0] ST_BB_FULL  = FIFO ? 32'h43 : 32'h1B;
    localparam logic [31:0] ST_BB_DONE  = FIFO ? 32'h04 : 32'h0C;
    localparam logic [31:0] ST_OVF      = FIFO ? 32'h4B : 32'h1B;
    localparam logic [31:0] ST_OVF_CLR  = FIFO ? 32'h43 : 32'h13;
    localparam int          N_BB        = FIFO ? 5 : 2;
    localparam int          BB_SPAN     = FIFO ? 160 : 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  width = '0;
    logic        write = 1'b0;
    logic [31:0] data_out;
    logic        tx;

    uart_tx_periph #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .address(address),
        .data_in(data_in),
        .width(width),
        .write(write),
        .data_out(data_out),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_seen = 0;
    bit         mon_busy = 1'b0;
    int         mon_c = 0;
    bit         mon_err = 1'b0;
    logic [9:0] mon_bits = '0;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;

    // Serial monitor: samples tx on the falling edge, every cycle of every bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx == 1'b0) begin
                mon_busy = 1'b1;
                mon_c    = 0;
                mon_err  = 1'b0;
                mon_bits = '0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_c++;
            if (mon_c % CPB == 0)
                mon_bits[mon_c / CPB] = tx;
            else if (tx !== mon_bits[mon_c / CPB])
                mon_err = 1'b1;
            if (mon_c == 10 * CPB - 1) begin
                mon_busy = 1'b0;
                mon_byte = mon_bits[8:1];
                frames_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame got=%02h required=none", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_byte !== mon_exp || mon_bits[9] !== 1'b1 || mon_err) begin
                        failures++;
                        $display("FAIL frame got=%02h stop=%b glitch=%0b required=%02h stop=1 glitch=0",
                                 mon_byte, mon_bits[9], mon_err, mon_exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] w);
        address = a;
        data_in = d;
        width   = w;
        write   = 1'b1;
        @(posedge clk);
        #1;
        write   = 1'b0;
        width   = '0;
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
        address = a;
        write   = 1'b0;
        @(posedge clk);
        #1;
        d = data_out;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
        end
    endtask

    logic [31:0] rd;
    int          f0;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_data_out", data_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(STAT, rd);
        check("reset_status", rd, 32'h04);

        // Single frame 0xA5
        exp_q.push_back(8'hA5);
        bus_write(BASE, 32'h0000_00A5, 4'b0001);
        check("latency_tx_high", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        check("latency_tx_low", {31'd0, tx}, 32'd0);
        wait_idle("single");
        bus_read(STAT, rd);
        check("single_status", rd, 32'h04);

        // Back-to-back writes
        start_q.delete();
        for (int i = 1; i <= 5; i++) begin
            if (i <= N_BB) exp_q.push_back(8'(i));
            bus_write(BASE, 32'(i), 4'b1111);
        end
        bus_read(STAT, rd);
        check("b2b_status_full", rd, ST_BB_FULL);
        wait_idle("b2b");
        check("b2b_frames", start_q.size(), N_BB);
        if (start_q.size() == N_BB)
            check("b2b_span", start_q[N_BB-1] - start_q[0], BB_SPAN);
        bus_read(STAT, rd);
        check("b2b_status_done", rd, ST_BB_DONE);
        bus_write(STAT, 32'h8, 4'b0001);
        bus_read(STAT, rd);
        check("b2b_status_clr", rd, 32'h04);

        // Overflow
        f0 = frames_seen;
        for (int i = 0; i < 6; i++) begin
            if (i < N_BB) exp_q.push_back(8'(8'h10 + i));
            bus_write(BASE, 32'(8'h10 + i), 4'b0001);
        end
        bus_read(STAT, rd);
        check("ovf_status", rd, ST_OVF);
        bus_write(STAT, 32'h8, 4'b0001);
        bus_read(STAT, rd);
        check("ovf_cleared", rd, ST_OVF_CLR);
        wait_idle("ovf");
        check("ovf_frames", frames_seen - f0, N_BB);

        // Decode and byte enables
        f0 = frames_seen;
        bus_write(BASE, 32'h0000_0077, 4'b0010);
        bus_write(BASE + 10'd8, 32'h0000_0066, 4'b0001);
        repeat (20) @(posedge clk);
        #1;
        check("decode_no_frames", frames_seen - f0, 0);
        bus_read(BASE + 10'd7, rd);
        check("status_alias", rd, 32'h04);
        bus_read(10'h100, rd);
        check("unmapped_read", rd, 32'd0);
        bus_read(STAT, rd);
        check("status_after_decode", rd, 32'h04);
        bus_read(BASE, rd);
        check("txdata_read", rd, 32'd0);

        // Mid-simulation reset
        bus_read(STAT, rd);
        rst_n = 1'b0;
        #1;
        check("midreset_data_out", data_out, 32'd0);
        check("midreset_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(STAT, rd);
        check("midreset_status", rd, 32'h04);

        // Reset during data bit 3 of 0x55 with bytes queued
        f0 = frames_seen;
        bus_write(BASE, 32'h55, 4'b0001);
        bus_write(BASE, 32'h66, 4'b0001);
        bus_write(BASE, 32'h77, 4'b0001);
        repeat (16) @(posedge clk);
        #2;
        check("abort_tx_bit3", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_tx_high", {31'd0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_frames", frames_seen - f0, 0);
        check("abort_tx_idle", {31'd0, tx}, 32'd1);
        bus_read(STAT, rd);
        check("abort_status", rd, 32'h04);

        check("pending_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
